// File: rtl/display_scan_controller.sv
// Time-multiplexed scan controller for common-anode digits sharing one hex decoder.
// Values enter through valid/ready and are committed only at frame boundaries.
//
//   state | meaning
//   BLANK | all anodes off for one digit period after reset
//   SCAN  | step through digits, DIV cycles each
module display_scan_controller #(
    parameter int N      = 4,
    parameter int DIGITS = 4,
    parameter int DIV    = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DIGITS*N-1:0]   load_data,
    input  logic                  blank_lz,
    output logic [N-1:0]          dec_in,
    output logic [DIGITS-1:0]     anode,
    output logic                  frame_start
);

    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [TW-1:0]     TICK_LAST = TW'(DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] ONE_HOT0  = {{(DIGITS-1){1'b0}}, 1'b1};

    typedef enum logic {BLANK, SCAN} state_t;

    state_t               state;
    logic [TW-1:0]        tick;
    logic [IW-1:0]        idx;
    logic [DIGITS*N-1:0]  active;
    logic [DIGITS*N-1:0]  shadow;
    logic                 pending;

    logic                 tick_done;
    logic                 commit;
    logic                 xfer;
    logic [DIGITS-1:0]    upper_zero;
    logic [N-1:0]         nibble;
    logic                 digit_blank;

    always_comb begin
        tick_done = (tick == TICK_LAST);
        commit    = tick_done && ((state == BLANK) || (idx == IDX_LAST));
        xfer      = load_valid && load_ready;
        // upper_zero[i]: nibbles i..DIGITS-1 of the active value are all zero
        for (int i = 0; i < DIGITS; i++) begin
            upper_zero[i] = ((active >> (i * N)) == '0);
        end
        nibble      = active[idx*N +: N];
        digit_blank = blank_lz && (idx != '0) && upper_zero[idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BLANK;
            tick        <= '0;
            idx         <= '0;
            active      <= '0;
            shadow      <= '0;
            pending     <= 1'b0;
            load_ready  <= 1'b1;
            anode       <= '1;
            dec_in      <= '0;
            frame_start <= 1'b0;
        end else begin
            tick <= tick_done ? '0 : tick + 1'b1;

            case (state)
                BLANK: begin
                    if (tick_done) begin
                        state <= SCAN;
                        idx   <= '0;
                    end
                end
                SCAN: begin
                    if (tick_done) begin
                        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    end
                end
                default: state <= BLANK;
            endcase

            // ready drops with the transfer itself so a held valid is never taken twice
            if (xfer) begin
                shadow     <= load_data;
                pending    <= 1'b1;
                load_ready <= 1'b0;
            end else begin
                load_ready <= !pending;
                if (commit && pending) begin
                    active  <= shadow;
                    pending <= 1'b0;
                end
            end

            frame_start <= (state == SCAN) && (idx == '0) && (tick == '0);
            if (state == SCAN) begin
                dec_in <= nibble;
                anode  <= digit_blank ? '1 : ~(ONE_HOT0 << idx);
            end else begin
                dec_in <= '0;
                anode  <= '1;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller with DIV=4, DIGITS=4.
module tb_display_scan_controller;

    localparam int N      = 4;
    localparam int DIGITS = 4;
    localparam int DIV    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic        blank_lz;
    logic [3:0]  dec_in;
    logic [3:0]  anode;
    logic        frame_start;

    display_scan_controller #(.N(N), .DIGITS(DIGITS), .DIV(DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .blank_lz    (blank_lz),
        .dec_in      (dec_in),
        .anode       (anode),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic        blz;
        logic [15:0] an;   // expected anode per digit, digit 3 in the top nibble
        logic [15:0] dec;  // expected dec_in per digit
    } vec_t;

    vec_t        vecs [8];
    vec_t        exp_q [$];
    vec_t        cur_vec;
    logic [15:0] disp_data;
    logic        ready_prev;
    logic        ready_cur;
    logic        got_xfer;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // One cycle: note a transfer about to happen, advance to the negedge, sample.
    task automatic sample();
        logic xfer_now;
        xfer_now = (load_valid === 1'b1) && (load_ready === 1'b1);
        if (xfer_now) exp_q.push_back(cur_vec);
        @(negedge clk);
        ready_prev = ready_cur;
        ready_cur  = load_ready;
        got_xfer   = xfer_now;
        if (xfer_now) begin
            check("ready_drop", 16'(load_ready), 16'd0);
            load_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        load_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample();
            check("rst_anode", 16'(anode), 16'hF);
            check("rst_dec", 16'(dec_in), 16'h0);
            check("rst_fs", 16'(frame_start), 16'd0);
            check("rst_ready", 16'(load_ready), 16'd1);
        end
        rst = 1'b0;
        exp_q.delete();
        disp_data  = 16'h0;
        ready_prev = 1'b1;
        ready_cur  = 1'b1;
    endtask

    // Blank period after reset, then nframes of the zero value, all digits lit.
    task automatic idle_frames(input int nframes);
        logic [3:0] ea;
        for (int k = 0; k < DIV; k++) begin
            sample();
            check("blank_anode", 16'(anode), 16'hF);
            check("blank_fs", 16'(frame_start), 16'd0);
        end
        for (int c = 0; c < nframes * DIGITS * DIV; c++) begin
            sample();
            ea = ~(4'b0001 << ((c / DIV) % DIGITS));
            check("idle_anode", 16'(anode), 16'(ea));
            check("idle_fs", 16'(frame_start), 16'((c % (DIGITS * DIV)) == 0));
            check("idle_dec", 16'(dec_in), 16'h0);
            check("idle_ready", 16'(load_ready), 16'd1);
        end
    endtask

    task automatic send(input vec_t v);
        cur_vec    = v;
        blank_lz   = v.blz;
        load_data  = v.data;
        load_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            sample();
            if (got_xfer) return;
        end
        check("send_timeout", 16'd1, 16'd0);
        load_valid = 1'b0;
    endtask

    // Wait for the frame that commits the oldest queued value, then check it.
    task automatic wait_frame();
        bit         found = 1'b0;
        vec_t       e;
        logic [3:0] ea;
        logic [3:0] ed;
        for (int k = 0; k < 200; k++) begin
            sample();
            if (frame_start && !ready_prev && ready_cur) begin
                found = 1'b1;
                break;
            end
            for (int j = 0; j < DIGITS; j++) begin
                if (anode[j] == 1'b0) check("old_value", 16'(dec_in), 16'(disp_data[j*4 +: 4]));
            end
            if (exp_q.size() != 0) check("ready_pending", 16'(load_ready), 16'd0);
        end
        if (!found) begin
            check("commit_timeout", 16'd1, 16'd0);
            return;
        end
        if (exp_q.size() == 0) begin
            check("unexpected_commit", 16'd1, 16'd0);
            return;
        end
        e = exp_q.pop_front();
        disp_data = e.data;
        for (int c = 0; c < DIGITS * DIV; c++) begin
            if (c != 0) sample();
            ea = 4'(e.an  >> (4 * (c / DIV)));
            ed = 4'(e.dec >> (4 * (c / DIV)));
            check("frame_anode", 16'(anode), 16'(ea));
            check("frame_dec", 16'(dec_in), 16'(ed));
            check("frame_fs", 16'(frame_start), 16'(c == 0));
        end
    endtask

    initial begin
        vecs[0] = '{data: 16'h12AF, blz: 1'b0, an: 16'h7BDE, dec: 16'h12AF};
        vecs[1] = '{data: 16'h0030, blz: 1'b1, an: 16'hFFDE, dec: 16'h0030};
        vecs[2] = '{data: 16'h0000, blz: 1'b1, an: 16'hFFFE, dec: 16'h0000};
        vecs[3] = '{data: 16'h0000, blz: 1'b0, an: 16'h7BDE, dec: 16'h0000};
        vecs[4] = '{data: 16'h0100, blz: 1'b1, an: 16'hFBDE, dec: 16'h0100};
        vecs[5] = '{data: 16'hF000, blz: 1'b1, an: 16'h7BDE, dec: 16'hF000};
        vecs[6] = '{data: 16'h9876, blz: 1'b0, an: 16'h7BDE, dec: 16'h9876};
        vecs[7] = '{data: 16'h5555, blz: 1'b0, an: 16'h7BDE, dec: 16'h5555};

        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = 16'h0;
        blank_lz   = 1'b0;
        cur_vec    = vecs[0];
        got_xfer   = 1'b0;

        do_reset();
        idle_frames(3);

        for (int i = 0; i < 6; i++) begin
            send(vecs[i]);
            wait_frame();
        end

        // second value held valid while the first is pending
        send(vecs[6]);
        cur_vec    = vecs[7];
        load_data  = vecs[7].data;
        load_valid = 1'b1;
        wait_frame();
        wait_frame();
        check("queue_empty", 16'(exp_q.size()), 16'd0);

        // reset shortly after a transfer discards the accepted value
        blank_lz = 1'b0;
        send(vecs[0]);
        sample();
        do_reset();
        idle_frames(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
